// File: rtl/lock_session_controller.sv
// rtl/lock_session_controller.sv - keypad lock session FSM: digit entry, code compare, lockout, auto-relock, reprogramming
// One shared timer serves the dwell (UNLOCKED/ALERT) and the entry-idle timeout (LOCKED/PROG).
module lock_session_controller #(
  parameter int                            DIGIT_W      = 4,
  parameter int                            CODE_LEN     = 4,
  parameter int                            MAX_TRIES    = 3,
  parameter logic [DIGIT_W*CODE_LEN-1:0]   DEFAULT_CODE = 16'hA5C3,
  parameter int                            UNLOCK_CYC   = 1000,
  parameter int                            ALERT_CYC    = 5000,
  parameter int                            ENTRY_TO_CYC = 500
) (
  input  logic               clk,
  input  logic               rst_btn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clr,
  input  logic               prog_req,
  output logic [2:0]         state,
  output logic [1:0]         try_count,
  output logic               led_locked,
  output logic               led_unlocked,
  output logic               led_alert
);
  localparam int CW      = DIGIT_W * CODE_LEN;
  localparam int NW      = $clog2(CODE_LEN + 1);
  localparam int MAX_AB  = (UNLOCK_CYC > ALERT_CYC) ? UNLOCK_CYC : ALERT_CYC;
  localparam int MAX_CYC = (MAX_AB > ENTRY_TO_CYC) ? MAX_AB : ENTRY_TO_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] UNL_LAST   = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] ALT_LAST   = TW'(ALERT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(ENTRY_TO_CYC - 1);
  localparam logic [TW-1:0] TMR_MAX    = '1;
  localparam logic [NW-1:0] LAST_DIGIT = NW'(CODE_LEN - 1);
  localparam logic [1:0]    TRY_MAX    = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROG     = 3'd3,
    S_ALERT    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] buf_q, buf_d;
  logic [CW-1:0] code_q, code_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [1:0]    try_q, try_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [CW-1:0] shifted;
  logic [TW-1:0] tmr_inc;
  logic          last_digit;

  // First digit lands in the most significant nibble once the entry is complete.
  assign shifted    = {buf_q[CW-DIGIT_W-1:0], key_digit};
  assign tmr_inc    = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TW'(1);
  assign last_digit = (cnt_q == LAST_DIGIT);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    try_d   = try_q;
    tmr_d   = tmr_inc;
    case (state_q)
      S_LOCKED: begin
        if (key_clr) begin
          buf_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (key_valid) begin
          buf_d = shifted;
          cnt_d = cnt_q + NW'(1);
          tmr_d = '0;
          if (last_digit) state_d = S_CHECK;
        end else if (cnt_q != '0) begin
          if (tmr_q == TO_LAST) begin
            buf_d = '0;
            cnt_d = '0;
            tmr_d = '0;
          end
        end else begin
          tmr_d = '0;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (buf_q == code_q) begin
          state_d = S_UNLOCKED;
          try_d   = '0;
        end else if (int'(try_q) + 1 >= MAX_TRIES) begin
          state_d = S_ALERT;
          try_d   = TRY_MAX;
        end else begin
          state_d = S_LOCKED;
          try_d   = try_q + 2'd1;
        end
      end
      S_UNLOCKED: begin
        // Expiry outranks a simultaneous programming request.
        if (tmr_q == UNL_LAST) begin
          state_d = S_LOCKED;
          tmr_d   = '0;
        end else if (prog_req) begin
          state_d = S_PROG;
          tmr_d   = '0;
        end
      end
      S_PROG: begin
        if (key_clr) begin
          buf_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (key_valid) begin
          tmr_d = '0;
          if (last_digit) begin
            code_d  = shifted;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_LOCKED;
          end else begin
            buf_d = shifted;
            cnt_d = cnt_q + NW'(1);
          end
        end else if (tmr_q == TO_LAST) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_LOCKED;
        end
      end
      S_ALERT: begin
        if (tmr_q == ALT_LAST) begin
          state_d = S_LOCKED;
          try_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_LOCKED;
        buf_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state_q <= S_LOCKED;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      try_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      try_q   <= try_d;
      tmr_q   <= tmr_d;
    end
  end

  assign state        = state_q;
  assign try_count    = try_q;
  assign led_locked   = (state_q == S_LOCKED) || (state_q == S_CHECK);
  assign led_unlocked = (state_q == S_UNLOCKED) || (state_q == S_PROG);
  assign led_alert    = (state_q == S_ALERT);

endmodule

// File: tb/tb_lock_session_controller.sv
// tb/tb_lock_session_controller.sv - vector table and scoreboard bench for lock_session_controller
// Expected state/try per clock edge come from the table or hand sequences; LEDs are decoded from expected state.
module tb_lock_session_controller;
  localparam logic [2:0] S_L = 3'd0, S_C = 3'd1, S_U = 3'd2, S_P = 3'd3, S_A = 3'd4;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'h0;
  logic       key_clr = 1'b0;
  logic       prog_req = 1'b0;
  logic [2:0] state;
  logic [1:0] try_count;
  logic       led_locked, led_unlocked, led_alert;

  always #5 clk = ~clk;

  lock_session_controller #(
    .UNLOCK_CYC  (8),
    .ALERT_CYC   (16),
    .ENTRY_TO_CYC(6)
  ) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_clr     (key_clr),
    .prog_req    (prog_req),
    .state       (state),
    .try_count   (try_count),
    .led_locked  (led_locked),
    .led_unlocked(led_unlocked),
    .led_alert   (led_alert)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       kc;
    logic       pr;
    logic [2:0] es;
    logic [1:0] et;
  } vec_t;

  typedef struct {
    logic [2:0] es;
    logic [1:0] et;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [2:0] led_of(input logic [2:0] s);
    return {s == S_A, (s == S_U) || (s == S_P), (s == S_L) || (s == S_C)};
  endfunction

  function automatic void add(input logic kv, input logic [3:0] kd, input logic kc,
                              input logic pr, input logic [2:0] es, input logic [1:0] et);
    tbl.push_back('{kv, kd, kc, pr, es, et});
  endfunction

  task automatic step(input logic kv, input logic [3:0] kd, input logic kc, input logic pr,
                      input logic [2:0] es, input logic [1:0] et);
    exp_t e;
    @(negedge clk);
    key_valid = kv;
    key_digit = kd;
    key_clr   = kc;
    prog_req  = pr;
    e.es = es;
    e.et = et;
    e.id = nstep;
    nstep++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard empty at step %0d", nstep);
    end else begin
      e = sb.pop_front();
      chk($sformatf("step%0d state", e.id), {5'b0, state}, {5'b0, e.es});
      chk($sformatf("step%0d try", e.id), {6'b0, try_count}, {6'b0, e.et});
      chk($sformatf("step%0d leds", e.id), {5'b0, led_alert, led_unlocked, led_locked},
          {5'b0, led_of(e.es)});
    end
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] es, input logic [1:0] et);
    step(1'b1, d, 1'b0, 1'b0, es, et);
  endtask

  task automatic idle(input int n, input logic [2:0] es, input logic [1:0] et);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, es, et);
  endtask

  task automatic code4(input logic [15:0] c, input logic [2:0] res,
                       input logic [1:0] t0, input logic [1:0] t1);
    press(c[15:12], S_L, t0);
    press(c[11:8], S_L, t0);
    press(c[7:4], S_L, t0);
    press(c[3:0], S_C, t0);
    idle(1, res, t1);
  endtask

  task automatic expire();
    idle(7, S_U, 2'd0);
    idle(1, S_L, 2'd0);
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    key_valid = 1'b0;
    key_clr   = 1'b0;
    prog_req  = 1'b0;
    rst_btn   = 1'b1;
    #1;
    chk({nm, " state"}, {5'b0, state}, 8'd0);
    chk({nm, " try"}, {6'b0, try_count}, 8'd0);
    chk({nm, " leds"}, {5'b0, led_alert, led_unlocked, led_locked}, 8'd1);
    @(negedge clk);
    rst_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset state", {5'b0, state}, 8'd0);
    chk("reset try", {6'b0, try_count}, 8'd0);
    chk("reset leds", {5'b0, led_alert, led_unlocked, led_locked}, 8'd1);
    rst_btn = 1'b0;

    // prog_req while locked is ignored; correct code unlocks then relocks after 8 cycles
    add(1'b0, 4'h0, 1'b0, 1'b1, S_L, 2'd0);
    add(1'b1, 4'hA, 1'b0, 1'b0, S_L, 2'd0);
    add(1'b1, 4'h5, 1'b0, 1'b0, S_L, 2'd0);
    add(1'b1, 4'hC, 1'b0, 1'b0, S_L, 2'd0);
    add(1'b1, 4'h3, 1'b0, 1'b0, S_C, 2'd0);
    add(1'b0, 4'h0, 1'b0, 1'b0, S_U, 2'd0);
    for (int i = 0; i < 7; i++) add(1'b0, 4'h0, 1'b0, 1'b0, S_U, 2'd0);
    add(1'b0, 4'h0, 1'b0, 1'b0, S_L, 2'd0);
    // three wrong codes escalate to ALERT
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) add(1'b1, 4'h1, 1'b0, 1'b0, S_L, 2'(k));
      add(1'b1, 4'h1, 1'b0, 1'b0, S_C, 2'(k));
      if (k < 2) add(1'b0, 4'h0, 1'b0, 1'b0, S_L, 2'(k + 1));
      else       add(1'b0, 4'h0, 1'b0, 1'b0, S_A, 2'd3);
    end
    for (int i = 0; i < 15; i++)
      add(i % 3 == 0, 4'hA, i % 3 == 1, i % 3 == 2, S_A, 2'd3);
    add(1'b0, 4'h0, 1'b0, 1'b0, S_L, 2'd0);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].kv, tbl[i].kd, tbl[i].kc, tbl[i].pr, tbl[i].es, tbl[i].et);

    code4(16'hA5C3, S_U, 2'd0, 2'd0);
    expire();

    // entry timeout keeps try_count, one cycle short keeps the partial entry
    code4(16'h1111, S_L, 2'd0, 2'd1);
    press(4'hA, S_L, 2'd1);
    press(4'h5, S_L, 2'd1);
    idle(6, S_L, 2'd1);
    code4(16'hA5C3, S_U, 2'd1, 2'd0);
    expire();
    press(4'hA, S_L, 2'd0);
    press(4'h5, S_L, 2'd0);
    idle(5, S_L, 2'd0);
    press(4'hC, S_L, 2'd0);
    press(4'h3, S_C, 2'd0);
    idle(1, S_U, 2'd0);
    expire();
    press(4'hA, S_L, 2'd0);
    press(4'h5, S_L, 2'd0);
    press(4'hC, S_L, 2'd0);
    step(1'b1, 4'h3, 1'b1, 1'b0, S_L, 2'd0);
    code4(16'hA5C3, S_U, 2'd0, 2'd0);
    expire();

    // reprogram to 1234 with PROG outlasting the unlock window
    code4(16'hA5C3, S_U, 2'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_P, 2'd0);
    press(4'h1, S_P, 2'd0);
    idle(4, S_P, 2'd0);
    press(4'h2, S_P, 2'd0);
    idle(4, S_P, 2'd0);
    press(4'h3, S_P, 2'd0);
    press(4'h4, S_L, 2'd0);
    code4(16'hA5C3, S_L, 2'd0, 2'd1);
    code4(16'h1234, S_U, 2'd1, 2'd0);
    expire();

    // PROG aborts on timeout with and without digits
    code4(16'h1234, S_U, 2'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_P, 2'd0);
    press(4'h7, S_P, 2'd0);
    press(4'h7, S_P, 2'd0);
    idle(5, S_P, 2'd0);
    idle(1, S_L, 2'd0);
    code4(16'h1234, S_U, 2'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_P, 2'd0);
    idle(5, S_P, 2'd0);
    idle(1, S_L, 2'd0);

    // expiry beats prog_req; one cycle earlier prog_req wins; key_clr restarts PROG entry
    code4(16'h1234, S_U, 2'd0, 2'd0);
    idle(7, S_U, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_L, 2'd0);
    code4(16'h1234, S_U, 2'd0, 2'd0);
    idle(6, S_U, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_P, 2'd0);
    press(4'h9, S_P, 2'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0, S_P, 2'd0);
    press(4'h5, S_P, 2'd0);
    press(4'h6, S_P, 2'd0);
    press(4'h7, S_P, 2'd0);
    press(4'h8, S_L, 2'd0);
    code4(16'h5678, S_U, 2'd0, 2'd0);
    expire();

    // asynchronous reset mid-PROG and mid-ALERT restores DEFAULT_CODE
    code4(16'h5678, S_U, 2'd0, 2'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, S_P, 2'd0);
    press(4'h1, S_P, 2'd0);
    press(4'h2, S_P, 2'd0);
    async_reset("prog rst");
    code4(16'hA5C3, S_U, 2'd0, 2'd0);
    expire();
    code4(16'h1111, S_L, 2'd0, 2'd1);
    code4(16'h1111, S_L, 2'd1, 2'd2);
    code4(16'h1111, S_A, 2'd2, 2'd3);
    idle(3, S_A, 2'd3);
    async_reset("alert rst");
    code4(16'hA5C3, S_U, 2'd0, 2'd0);
    expire();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_session_controller.md
Name: lock_session_controller

Overview:
Sequencing controller for the digital lock: collects multi-digit keypad entries, schedules the code compare, and counts wrong attempts. Drives the LOCKED/UNLOCKED/ALERT indicators and applies timed auto-relock, timed alert auto-reset and an entry timeout. While unlocked it also handles reprogramming of the stored code. It sits between the keypad debouncer/strobe logic and the indicator LEDs, and replaces the single-shot compare path with a full session state machine.

Parameters:
DIGIT_W, 4, bits per keypad digit
CODE_LEN, 4, digits per code
MAX_TRIES, 3, wrong codes that trigger ALERT (2..3)
DEFAULT_CODE, 16'hA5C3, code loaded at reset (CODE_LEN*DIGIT_W bits)
UNLOCK_CYC, 1000, cycles spent in UNLOCKED before auto-relock
ALERT_CYC, 5000, cycles spent in ALERT before auto-reset
ENTRY_TO_CYC, 500, idle cycles after a partial entry before the buffer is discarded

Ports:
clk  in  1  system clock, rising edge
rst_btn  in  1  reset, asynchronous, active-high
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  DIGIT_W  digit value
key_clr  in  1  one-cycle strobe: discard partial entry
prog_req  in  1  one-cycle strobe: enter code-programming mode (honoured only in UNLOCKED)
state  out  3  LOCKED=0, CHECK=1, UNLOCKED=2, PROG=3, ALERT=4
try_count  out  2  wrong attempts since last success/auto-reset
led_locked  out  1  state is LOCKED or CHECK
led_unlocked  out  1  state is UNLOCKED or PROG
led_alert  out  1  state is ALERT

Behaviour:
- Reset: state=LOCKED, try_count=0, entry buffer=0, digit count=0, all timers=0, stored code=DEFAULT_CODE. LEDs decode combinationally from state, so led_locked=1 and the others are 0.
- Entry buffer: each accepted digit shifts in from the LSB end, so the first digit ends in the MS nibble. The digit count increments by 1 per accepted digit.
- LOCKED: key_valid accepts a digit. On the cycle the CODE_LEN-th digit is accepted, next state=CHECK. key_clr clears the buffer and count; key_clr wins over key_valid in the same cycle. prog_req is ignored.
- Entry timeout: while 0 < digit count < CODE_LEN, an idle counter runs and resets on each accepted key. When it reaches ENTRY_TO_CYC, the buffer and count are cleared. This does not count as a wrong attempt.
- CHECK (exactly 1 cycle, keys ignored): the full buffer is compared with the stored code, and the buffer and count are cleared.
  - Match -> UNLOCKED, try_count=0.
  - Mismatch with try_count+1 == MAX_TRIES -> ALERT, try_count saturates at MAX_TRIES.
  - Any other mismatch -> LOCKED, try_count+1.
- Latency: last digit strobed at edge N -> CHECK after edge N; the result state is visible after edge N+1.
- UNLOCKED: remains for exactly UNLOCK_CYC cycles, then -> LOCKED. key_valid and key_clr are ignored.
  - prog_req -> PROG and the unlock timer stops.
  - Timer expiry in the same cycle as prog_req: expiry wins (-> LOCKED).
- PROG: accepts CODE_LEN digits using the same shift rules. After the last digit the stored code is updated and the next state is LOCKED.
  - key_clr restarts entry without leaving PROG.
  - Entry timeout in PROG: abort to LOCKED with the stored code unchanged. The timeout also applies with 0 digits, counted from PROG entry.
- ALERT: all key inputs are ignored. After exactly ALERT_CYC cycles -> LOCKED with try_count=0 and the buffer cleared (auto reset).
- rst_btn mid-operation (any state, including PROG mid-entry): immediate return to reset values. The stored code reverts to DEFAULT_CODE.
- Timer widths are sized with $clog2 of the largest *_CYC parameter. Counters never wrap.
- try_count never exceeds MAX_TRIES.
- Illegal state encodings (5–7) -> LOCKED on the next edge.

Test Plan:
All scenarios use overrides UNLOCK_CYC=8, ALERT_CYC=16, ENTRY_TO_CYC=6.
1. Correct code: digits A,5,C,3 on consecutive cycles -> CHECK for 1 cycle, then UNLOCKED with led_unlocked=1 and try_count=0. Exactly 8 cycles later state=LOCKED.
2. Lockout: three wrong codes (1,1,1,1) -> try_count goes 1, 2. The third CHECK -> ALERT with led_alert=1. Keys pressed during ALERT have no effect. After 16 cycles state=LOCKED and try_count=0.
3. Entry timeout and clear: enter A,5 then idle 6 cycles -> buffer cleared and try_count unchanged; A,5,C,3 then unlocks. Separately, key_clr and key_valid in the same cycle -> digit dropped and count=0.
4. Reprogram: unlock, prog_req, enter 1,2,3,4 -> LOCKED. Entering A,5,C,3 now fails with try_count=1; entering 1,2,3,4 unlocks.
5. Program abort and races: in PROG enter 7,7 then idle 6 cycles -> LOCKED and the old code still unlocks. prog_req on the UNLOCKED expiry cycle -> LOCKED, not PROG.
6. Async reset: assert rst_btn mid-PROG and mid-ALERT -> outputs go to reset values without a clock edge, and DEFAULT_CODE unlocks.
